front_panel_ctrl: RTL and testbench
===================================

# front_panel_ctrl

Front-panel run/halt sequencer for the PDP-8 CPU. It synchronizes and debounces the operator switches CLEAR, RUN, HALT and STEP, and turns them into one-cycle events. A state machine then gates the CPU's instruction sequencer through `cpuRun` and drives the machine-clear pulse `cpuClear`. Halts only ever take effect at an instruction boundary, whether requested from the panel or by an OPR HLT.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required before a switch level is accepted; must be ≥2.
- `CLEAR_CYCLES`, default 4: length of the `cpuClear` pulse in cycles; must be ≥1.

Ports:
- `SYSCLK` in 1: system clock; everything is in this domain.
- `RESET` in 1: asynchronous, active-high reset.
- `sw_CLEAR`, `sw_RUN`, `sw_HALT`, `sw_STEP` in 1 each: raw switch inputs, active-high, asynchronous, may bounce.
- `instDone` in 1: CPU pulses this high for the final cycle of every instruction.
- `hltInst` in 1: the current instruction is OPR HLT; only meaningful while `instDone`=1.
- `cpuRun` out 1: CPU sequencer advances only while this is high.
- `cpuClear` out 1: synchronous clear of AC, L, IR and the major-state register.
- `runLed` out 1: equals `cpuRun`.

## Operation

Switch conditioning:
- Each switch passes through a 2-FF synchronizer, then a debounce counter.
- The debounced level flips on the `DEBOUNCE_CYCLES`-th consecutive cycle in which the synchronized sample differs from it.
- Any matching sample resets the counter to 0.
- A rising edge of the debounced level produces a registered one-cycle event: `clrEv`, `runEv`, `haltEv` or `stepEv`. Falling edges produce nothing.
- If several events fire in the same cycle, only the highest-priority one is acted on: CLEAR > HALT > RUN > STEP. The rest are dropped.

State machine (Moore outputs; `cpuRun`=1 in RUNNING, STEPPING and STOPPING; `cpuClear`=1 only in CLEARING):
- HALTED:
  - `clrEv` → CLEARING, with the clear counter loaded to `CLEAR_CYCLES`-1.
  - `runEv` → RUNNING.
  - `stepEv` → STEPPING.
  - `haltEv` is ignored.
- CLEARING:
  - The counter decrements each cycle; when it reaches 0 → HALTED.
  - All events in this state are dropped.
- RUNNING:
  - `instDone`&`hltInst` → HALTED.
  - Otherwise `haltEv` → STOPPING; if `instDone`=1 in that same cycle → HALTED directly.
  - `clrEv`, `runEv` and `stepEv` are ignored, because clear is legal only while halted.
- STEPPING and STOPPING:
  - `instDone` → HALTED.
  - All events are ignored.
- The state encoding has exactly 5 states. Any unreachable encoding → HALTED.

## Timing

- Reset values: state HALTED; `cpuRun`=0, `cpuClear`=0, `runLed`=0; debounced levels 0; all counters 0.
- Reset asserted mid-operation:
  - Takes effect immediately and asynchronously; `cpuRun` and `cpuClear` drop with no wait for an instruction boundary.
  - A switch still held when reset is released is debounced from 0, so it produces an event `DEBOUNCE_CYCLES`+3 edges after release.
- Switch-to-event latency: a clean raw rising edge held stable yields an event exactly `DEBOUNCE_CYCLES`+3 `SYSCLK` edges later.
- Glitch rejection: a pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no event.
- Event-to-output latency: an event in cycle n changes the state at edge n+1; `cpuRun`/`cpuClear` follow in cycle n+1.
- Instruction boundary: `instDone` sampled high in cycle n gives `cpuRun`=0 in cycle n+1. The CPU therefore never begins the next instruction.
- `cpuClear` is high for exactly `CLEAR_CYCLES` consecutive cycles.

## Structure

- Shared package `pdp8_pkg`: the front-panel state encodings (HALTED=0, CLEARING, RUNNING, STEPPING, STOPPING) and the event-priority ordering.
- Sub-module `sw_debounce` (synchronizer, counter and edge detector, parameterized by `DEBOUNCE_CYCLES`), instantiated 4×.
- The state machine and clear counter sit in `front_panel_ctrl` itself.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4 and `CLEAR_CYCLES`=4.

- **Clear:** press `sw_CLEAR` while halted → `cpuClear`=1 for exactly 4 cycles, starting 8 edges after the press; `cpuRun` stays 0.
- **Bounce:** toggle `sw_RUN` with 2-cycle pulses for 20 cycles, then hold it high → exactly one `runEv`; `cpuRun` rises 8 edges after the final stable rise and remains 1.
- **Run then HLT:** run; drive `instDone`=1 with `hltInst`=1 at cycle 50 → `cpuRun`=0 at cycle 51 and the state is HALTED.
- **Panel halt:** while running, press `sw_HALT`, then pulse `instDone` 10 cycles later → `cpuRun` stays 1 through the `instDone` cycle and is 0 one cycle after it.
  - Repeat with `haltEv` and `instDone` in the same cycle → HALTED the next cycle.
- **Single step:** press `sw_STEP` while halted → `cpuRun`=1 until the first `instDone`, then 0.
  - A second `sw_STEP` press repeats this.
  - Pressing `sw_CLEAR` while stepping has no effect.
- **Reset and priority:** assert `RESET` mid-CLEARING → `cpuClear` drops asynchronously.
  - After release, press `sw_CLEAR` and `sw_RUN` so their events coincide → CLEARING wins; `cpuRun` stays 0.

Source files
------------

// File: rtl/pdp8_pkg.sv
// Shared front-panel definitions for the PDP-8: sequencer state encodings
// and the ordering used when several panel events arrive in the same cycle.
package pdp8_pkg;

  localparam logic [2:0] ST_HALTED   = 3'd0;
  localparam logic [2:0] ST_CLEARING = 3'd1;
  localparam logic [2:0] ST_RUNNING  = 3'd2;
  localparam logic [2:0] ST_STEPPING = 3'd3;
  localparam logic [2:0] ST_STOPPING = 3'd4;

  // Field order doubles as priority order: clr is the MSB and wins.
  typedef struct packed {
    logic clr;
    logic halt;
    logic run;
    logic step;
  } panel_ev_t;

  function automatic panel_ev_t ev_priority(input panel_ev_t ev);
    panel_ev_t win;
    win = '0;
    if (ev.clr)       win.clr  = 1'b1;
    else if (ev.halt) win.halt = 1'b1;
    else if (ev.run)  win.run  = 1'b1;
    else if (ev.step) win.step = 1'b1;
    return win;
  endfunction

endpackage

// File: rtl/front_panel_ctrl_if.sv
// Operator switches, CPU handshake and panel outputs of the run/halt sequencer.
interface front_panel_ctrl_if;
  logic sw_CLEAR;
  logic sw_RUN;
  logic sw_HALT;
  logic sw_STEP;
  logic instDone;
  logic hltInst;
  logic cpuRun;
  logic cpuClear;
  logic runLed;

  modport master (
    output sw_CLEAR, sw_RUN, sw_HALT, sw_STEP, instDone, hltInst,
    input  cpuRun, cpuClear, runLed
  );

  modport slave (
    input  sw_CLEAR, sw_RUN, sw_HALT, sw_STEP, instDone, hltInst,
    output cpuRun, cpuClear, runLed
  );
endinterface

// File: rtl/sw_debounce.sv
// One operator switch: 2-FF synchronizer, stability counter and a registered
// one-cycle event on each accepted rising level.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic ev
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          prev_reg;
  logic          ev_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      prev_reg  <= 1'b0;
      ev_reg    <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= sw;
      sync2_reg <= sync1_reg;
      prev_reg  <= level_reg;
      ev_reg    <= level_reg & ~prev_reg;
      // Level flips on the Nth consecutive disagreeing sample; any agreement restarts.
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign ev = ev_reg;

endmodule

// File: rtl/front_panel_ctrl.sv
// PDP-8 front-panel run/halt sequencer: conditions the panel switches and gates
// the CPU sequencer so halts only land on instruction boundaries.
module front_panel_ctrl
  import pdp8_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CLEAR_CYCLES    = 4
) (
  input logic              SYSCLK,
  input logic              RESET,
  front_panel_ctrl_if.slave pnl
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  logic [3:0] raw_sw;
  logic [3:0] ev_raw;
  panel_ev_t  ev;

  assign raw_sw = {pnl.sw_CLEAR, pnl.sw_HALT, pnl.sw_RUN, pnl.sw_STEP};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sw
      sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk (SYSCLK),
        .rst (RESET),
        .sw  (raw_sw[gi]),
        .ev  (ev_raw[gi])
      );
    end
  endgenerate

  assign ev = ev_priority(panel_ev_t'(ev_raw));

  logic [2:0]       state_reg;
  logic [2:0]       state_next;
  logic [CLR_W-1:0] clr_cnt_reg;
  logic [CLR_W-1:0] clr_cnt_next;

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      ST_HALTED: begin
        if (ev.clr) begin
          state_next   = ST_CLEARING;
          clr_cnt_next = CLR_LAST;
        end else if (ev.run) begin
          state_next = ST_RUNNING;
        end else if (ev.step) begin
          state_next = ST_STEPPING;
        end
      end
      ST_CLEARING: begin
        if (clr_cnt_reg == '0) state_next = ST_HALTED;
        else                   clr_cnt_next = clr_cnt_reg - 1'b1;
      end
      ST_RUNNING: begin
        // A panel halt coinciding with an instruction boundary stops right away.
        if (pnl.instDone && pnl.hltInst) state_next = ST_HALTED;
        else if (ev.halt)                state_next = pnl.instDone ? ST_HALTED : ST_STOPPING;
      end
      ST_STEPPING, ST_STOPPING: begin
        if (pnl.instDone) state_next = ST_HALTED;
      end
      default: state_next = ST_HALTED;
    endcase
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state_reg   <= ST_HALTED;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  assign pnl.cpuRun   = (state_reg == ST_RUNNING) || (state_reg == ST_STEPPING) ||
                        (state_reg == ST_STOPPING);
  assign pnl.cpuClear = (state_reg == ST_CLEARING);
  assign pnl.runLed   = pnl.cpuRun;

endmodule

// File: tb/tb_front_panel_ctrl.sv
// Directed bench for front_panel_ctrl with DEBOUNCE_CYCLES=4, CLEAR_CYCLES=4.
module tb_front_panel_ctrl;
  import pdp8_pkg::*;

  logic SYSCLK = 1'b0;
  logic RESET  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  front_panel_ctrl_if pnl();

  front_panel_ctrl #(.DEBOUNCE_CYCLES(4), .CLEAR_CYCLES(4)) dut (
    .SYSCLK (SYSCLK),
    .RESET  (RESET),
    .pnl    (pnl)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Advance one edge and settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    pnl.sw_CLEAR = 0; pnl.sw_RUN = 0; pnl.sw_HALT = 0; pnl.sw_STEP = 0;
    pnl.instDone = 0; pnl.hltInst = 0;
    RESET = 1;
    idle(2);
    checks++; if (pnl.cpuRun !== 1'b0) begin errors++; $display("FAIL reset_cpuRun: got %b expected 0", pnl.cpuRun); end
    checks++; if (pnl.cpuClear !== 1'b0) begin errors++; $display("FAIL reset_cpuClear: got %b expected 0", pnl.cpuClear); end
    checks++; if (pnl.runLed !== 1'b0) begin errors++; $display("FAIL reset_runLed: got %b expected 0", pnl.runLed); end
    checks++; if (dut.state_reg !== ST_HALTED) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_reg, ST_HALTED); end
    RESET = 0;
    idle(10);
    checks++; if (pnl.cpuRun !== 1'b0 || pnl.cpuClear !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got run=%b clr=%b expected 0/0", pnl.cpuRun, pnl.cpuClear); end
  endtask

  task automatic test_clear();
    pnl.sw_CLEAR = 1;
    idle(7);
    checks++; if (pnl.cpuClear !== 1'b0) begin errors++; $display("FAIL clear_early: got %b expected 0", pnl.cpuClear); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pnl.cpuClear !== 1'b1 || pnl.cpuRun !== 1'b0) begin errors++; $display("FAIL clear_pulse[%0d]: got clr=%b run=%b expected 1/0", i, pnl.cpuClear, pnl.cpuRun); end
    end
    tick();
    checks++; if (pnl.cpuClear !== 1'b0) begin errors++; $display("FAIL clear_end: got %b expected 0", pnl.cpuClear); end
    pnl.sw_CLEAR = 0;
    idle(12);
    checks++; if (pnl.cpuClear !== 1'b0 || pnl.cpuRun !== 1'b0) begin errors++; $display("FAIL clear_release: got clr=%b run=%b expected 0/0", pnl.cpuClear, pnl.cpuRun); end
  endtask

  task automatic test_bounce();
    int run_evs;
    int run_drops;
    run_evs = 0;
    run_drops = 0;
    for (int i = 0; i < 5; i++) begin
      pnl.sw_RUN = 1;
      tick(); if (dut.ev_raw[1]) run_evs++;
      tick(); if (dut.ev_raw[1]) run_evs++;
      pnl.sw_RUN = 0;
      tick(); if (dut.ev_raw[1]) run_evs++;
      tick(); if (dut.ev_raw[1]) run_evs++;
    end
    pnl.sw_RUN = 1;
    for (int i = 0; i < 7; i++) begin
      tick(); if (dut.ev_raw[1]) run_evs++;
    end
    checks++; if (pnl.cpuRun !== 1'b0) begin errors++; $display("FAIL bounce_early: got %b expected 0", pnl.cpuRun); end
    tick(); if (dut.ev_raw[1]) run_evs++;
    checks++; if (pnl.cpuRun !== 1'b1 || pnl.runLed !== 1'b1) begin errors++; $display("FAIL bounce_run: got run=%b led=%b expected 1/1", pnl.cpuRun, pnl.runLed); end
    for (int i = 0; i < 20; i++) begin
      tick(); if (dut.ev_raw[1]) run_evs++;
      if (pnl.cpuRun !== 1'b1) run_drops++;
    end
    checks++; if (run_drops !== 0) begin errors++; $display("FAIL bounce_hold: got %0d dropped cycles expected 0", run_drops); end
    checks++; if (run_evs !== 1) begin errors++; $display("FAIL bounce_events: got %0d run events expected 1", run_evs); end
    pnl.sw_RUN = 0;
    idle(12);
  endtask

  task automatic test_run_hlt();
    idle(5);
    pnl.instDone = 1; pnl.hltInst = 0;
    tick();
    pnl.instDone = 0;
    checks++; if (pnl.cpuRun !== 1'b1) begin errors++; $display("FAIL plain_instdone: got %b expected 1", pnl.cpuRun); end
    idle(10);
    pnl.instDone = 1; pnl.hltInst = 1;
    #1;
    checks++; if (pnl.cpuRun !== 1'b1) begin errors++; $display("FAIL hlt_cycle: got %b expected 1", pnl.cpuRun); end
    tick();
    pnl.instDone = 0; pnl.hltInst = 0;
    checks++; if (pnl.cpuRun !== 1'b0) begin errors++; $display("FAIL hlt_stop: got %b expected 0", pnl.cpuRun); end
    checks++; if (dut.state_reg !== ST_HALTED) begin errors++; $display("FAIL hlt_state: got %0d expected %0d", dut.state_reg, ST_HALTED); end
  endtask

  task automatic start_running(input string tag);
    pnl.sw_RUN = 1;
    idle(8);
    checks++; if (pnl.cpuRun !== 1'b1) begin errors++; $display("FAIL %s_run: got %b expected 1", tag, pnl.cpuRun); end
    pnl.sw_RUN = 0;
    idle(12);
  endtask

  task automatic test_panel_halt();
    start_running("phalt");
    pnl.sw_HALT = 1;
    idle(8);
    idle(10);
    checks++; if (dut.state_reg !== ST_STOPPING || pnl.cpuRun !== 1'b1) begin errors++; $display("FAIL phalt_stopping: got state=%0d run=%b expected %0d/1", dut.state_reg, pnl.cpuRun, ST_STOPPING); end
    pnl.instDone = 1;
    #1;
    checks++; if (pnl.cpuRun !== 1'b1) begin errors++; $display("FAIL phalt_boundary: got %b expected 1", pnl.cpuRun); end
    tick();
    pnl.instDone = 0;
    checks++; if (pnl.cpuRun !== 1'b0 || dut.state_reg !== ST_HALTED) begin errors++; $display("FAIL phalt_stop: got run=%b state=%0d expected 0/%0d", pnl.cpuRun, dut.state_reg, ST_HALTED); end
    pnl.sw_HALT = 0;
    idle(12);

    start_running("phalt_same");
    pnl.sw_HALT = 1;
    idle(7);
    pnl.instDone = 1;
    checks++; if (dut.ev_raw[2] !== 1'b1) begin errors++; $display("FAIL phalt_same_ev: got %b expected 1", dut.ev_raw[2]); end
    tick();
    pnl.instDone = 0;
    checks++; if (pnl.cpuRun !== 1'b0 || dut.state_reg !== ST_HALTED) begin errors++; $display("FAIL phalt_same_stop: got run=%b state=%0d expected 0/%0d", pnl.cpuRun, dut.state_reg, ST_HALTED); end
    pnl.sw_HALT = 0;
    idle(12);
  endtask

  task automatic test_step();
    for (int n = 0; n < 2; n++) begin
      pnl.sw_STEP = 1;
      idle(7);
      checks++; if (pnl.cpuRun !== 1'b0) begin errors++; $display("FAIL step%0d_early: got %b expected 0", n, pnl.cpuRun); end
      tick();
      checks++; if (pnl.cpuRun !== 1'b1 || dut.state_reg !== ST_STEPPING) begin errors++; $display("FAIL step%0d_start: got run=%b state=%0d expected 1/%0d", n, pnl.cpuRun, dut.state_reg, ST_STEPPING); end
      pnl.sw_STEP = 0;
      if (n == 0) begin
        pnl.sw_CLEAR = 1;
        idle(12);
        checks++; if (pnl.cpuClear !== 1'b0 || dut.state_reg !== ST_STEPPING) begin errors++; $display("FAIL step_clear_ignored: got clr=%b state=%0d expected 0/%0d", pnl.cpuClear, dut.state_reg, ST_STEPPING); end
        pnl.sw_CLEAR = 0;
      end
      idle(12);
      checks++; if (pnl.cpuRun !== 1'b1) begin errors++; $display("FAIL step%0d_hold: got %b expected 1", n, pnl.cpuRun); end
      pnl.instDone = 1;
      tick();
      pnl.instDone = 0;
      checks++; if (pnl.cpuRun !== 1'b0 || dut.state_reg !== ST_HALTED) begin errors++; $display("FAIL step%0d_done: got run=%b state=%0d expected 0/%0d", n, pnl.cpuRun, dut.state_reg, ST_HALTED); end
      idle(4);
    end
  endtask

  task automatic test_reset_priority();
    pnl.sw_CLEAR = 1;
    idle(9);
    checks++; if (pnl.cpuClear !== 1'b1) begin errors++; $display("FAIL rst_clearing: got %b expected 1", pnl.cpuClear); end
    #2 RESET = 1;
    #1;
    checks++; if (pnl.cpuClear !== 1'b0 || pnl.cpuRun !== 1'b0) begin errors++; $display("FAIL rst_async: got clr=%b run=%b expected 0/0", pnl.cpuClear, pnl.cpuRun); end
    idle(3);
    RESET = 0;
    idle(7);
    checks++; if (pnl.cpuClear !== 1'b0) begin errors++; $display("FAIL rst_held_early: got %b expected 0", pnl.cpuClear); end
    tick();
    checks++; if (pnl.cpuClear !== 1'b1) begin errors++; $display("FAIL rst_held_event: got %b expected 1", pnl.cpuClear); end
    pnl.sw_CLEAR = 0;
    idle(16);
    pnl.sw_CLEAR = 1; pnl.sw_RUN = 1;
    idle(7);
    checks++; if (dut.ev_raw[3] !== 1'b1 || dut.ev_raw[1] !== 1'b1) begin errors++; $display("FAIL prio_coincide: got clr_ev=%b run_ev=%b expected 1/1", dut.ev_raw[3], dut.ev_raw[1]); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pnl.cpuClear !== 1'b1 || pnl.cpuRun !== 1'b0) begin errors++; $display("FAIL prio_clear[%0d]: got clr=%b run=%b expected 1/0", i, pnl.cpuClear, pnl.cpuRun); end
    end
    idle(6);
    checks++; if (pnl.cpuRun !== 1'b0 || dut.state_reg !== ST_HALTED) begin errors++; $display("FAIL prio_after: got run=%b state=%0d expected 0/%0d", pnl.cpuRun, dut.state_reg, ST_HALTED); end
    pnl.sw_CLEAR = 0; pnl.sw_RUN = 0;
    idle(12);
  endtask

  initial begin
    test_reset();
    test_clear();
    test_bounce();
    test_run_hlt();
    test_panel_halt();
    test_step();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
